// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared types and sizing for the decode issue scoreboard.
// Optional same-cycle writeback bypass of source hazards: SCOREBOARD_WB_BYPASS_EN.
package decode_issue_scoreboard_pkg;

   localparam int unsigned REGISTER_DEPTH = 32;
   localparam int unsigned MAX_INFLIGHT   = 4;
   localparam int unsigned FLUSH_CYCLES   = 2;

   localparam int unsigned IDX_W  = $clog2(REGISTER_DEPTH);
   localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef logic [IDX_W-1:0] reg_index_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FLUSH
   } scoreboard_state_t;

endpackage

// File: rtl/decode_issue_scoreboard_counter_bank.sv
// Per-register pending-write counters plus the in-flight total.
// Register 0 is never tracked; a same-cycle increment and decrement of one register cancel.
module decode_issue_scoreboard_counter_bank
   import decode_issue_scoreboard_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_i,
   input  logic                      inc_i,
   input  reg_index_t                inc_idx_i,
   input  logic                      dec_i,
   input  reg_index_t                dec_idx_i,
   output cnt_t                      cnt_o [REGISTER_DEPTH],
   output cnt_t                      total_o,
   output logic [REGISTER_DEPTH-1:0] busy_mask_o
);

   cnt_t cnt_q [REGISTER_DEPTH];
   cnt_t cnt_d [REGISTER_DEPTH];
   cnt_t total_q, total_d;
   logic inc_ok, dec_ok;

   assign inc_ok = inc_i && (inc_idx_i != '0);
   assign dec_ok = dec_i && (dec_idx_i != '0);

   always_comb begin : next_counts
      cnt_d   = cnt_q;
      total_d = total_q;
      if (clr_i) begin
         for (int i = 0; i < int'(REGISTER_DEPTH); i++) cnt_d[i] = '0;
         total_d = '0;
      end else begin
         if (inc_ok) cnt_d[inc_idx_i] = cnt_d[inc_idx_i] + CNT_W'(1);
         if (dec_ok) cnt_d[dec_idx_i] = cnt_d[dec_idx_i] - CNT_W'(1);
         total_d = total_q + CNT_W'(inc_ok) - CNT_W'(dec_ok);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(REGISTER_DEPTH); i++) cnt_q[i] <= '0;
         total_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         total_q <= total_d;
      end
   end

   always_comb begin : busy_bits
      busy_mask_o = '0;
      for (int i = 1; i < int'(REGISTER_DEPTH); i++) busy_mask_o[i] = (cnt_q[i] != '0);
   end

   assign cnt_o   = cnt_q;
   assign total_o = total_q;

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Decode-to-execute issue controller: register hazard scoreboard, RUN/STALL/FLUSH sequencing, stall perf counter.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release a source hazard without a bubble.
module decode_issue_scoreboard
   import decode_issue_scoreboard_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  reg_index_t                issue_rs1,
   input  reg_index_t                issue_rs2,
   input  reg_index_t                issue_rd,
   input  logic                      issue_rs1_used,
   input  logic                      issue_rs2_used,
   input  logic                      issue_rd_write,
   input  logic                      execute_ready,
   input  logic                      wb_valid,
   input  reg_index_t                wb_rd,
   input  logic                      flush,
   output logic                      stall,
   output logic [REGISTER_DEPTH-1:0] busy_mask,
   output logic [31:0]               stall_cycles,
   output logic                      wb_underflow
);

   scoreboard_state_t state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [31:0]       stall_cycles_q, stall_cycles_d;
   logic              wb_underflow_q, wb_underflow_d;

   cnt_t cnt [REGISTER_DEPTH];
   cnt_t total;
   logic rs1_busy_c, rs2_busy_c, rd_full_c, hazard_c;
   logic fire_c, wb_live_c, inc_c, dec_c;

   decode_issue_scoreboard_counter_bank u_scoreboard_counter_bank (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (flush),
      .inc_i       (inc_c),
      .inc_idx_i   (issue_rd),
      .dec_i       (dec_c),
      .dec_idx_i   (wb_rd),
      .cnt_o       (cnt),
      .total_o     (total),
      .busy_mask_o (busy_mask)
   );

   // Source operands are busy while any write to them is still pending.
   always_comb begin : src_check
      rs1_busy_c = issue_rs1_used && (issue_rs1 != '0) && (cnt[issue_rs1] != '0);
      rs2_busy_c = issue_rs2_used && (issue_rs2 != '0) && (cnt[issue_rs2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_W'(1))) rs1_busy_c = 1'b0;
      if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_W'(1))) rs2_busy_c = 1'b0;
`endif
   end

   assign rd_full_c = issue_rd_write && (issue_rd != '0) &&
                      ((cnt[issue_rd] == CNT_W'(MAX_INFLIGHT)) || (total == CNT_W'(MAX_INFLIGHT)));
   assign hazard_c    = rs1_busy_c || rs2_busy_c || rd_full_c || !execute_ready;
   assign issue_ready = rst && (state_q != FLUSH) && !hazard_c;
   assign fire_c      = issue_valid && issue_ready;

   // Flush wins over both issue and writeback; FLUSH state swallows writebacks.
   assign wb_live_c = wb_valid && (wb_rd != '0) && (state_q != FLUSH) && !flush;
   assign inc_c     = fire_c && issue_rd_write && (issue_rd != '0) && !flush;
   assign dec_c     = wb_live_c && (cnt[wb_rd] != '0);

   always_comb begin : fsm_next
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (flush) begin
         state_d = FLUSH;
         fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
      end else begin
         unique case (state_q)
            RUN:     if (issue_valid && !issue_ready) state_d = STALL;
            STALL:   if (issue_ready || !issue_valid) state_d = RUN;
            FLUSH: begin
               if (fcnt_q == '0) state_d = RUN;
               else              fcnt_d  = fcnt_q - FCNT_W'(1);
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin : perf_next
      stall_cycles_d = stall_cycles_q;
      wb_underflow_d = wb_underflow_q || (wb_live_c && (cnt[wb_rd] == '0));
      if ((state_q == STALL) && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= RUN;
         fcnt_q         <= '0;
         stall_cycles_q <= '0;
         wb_underflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         stall_cycles_q <= stall_cycles_d;
         wb_underflow_q <= wb_underflow_d;
      end
   end

   assign stall        = (state_q == STALL);
   assign stall_cycles = stall_cycles_q;
   assign wb_underflow = wb_underflow_q;

endmodule
